// File: rtl/countdown_timer.sv
// rtl/countdown_timer.sv - hh:mm:ss down-counter with run/pause/expire control and one-cycle done pulse
module countdown_timer #(
  parameter int HOUR_MAX = 23
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ld,
  input  logic [4:0] hour_in,
  input  logic [5:0] min_in,
  input  logic [5:0] sec_in,
  input  logic       tick,
  input  logic       start,
  input  logic       stop,
  output logic [4:0] hour_out,
  output logic [5:0] min_out,
  output logic [5:0] sec_out,
  output logic       running,
  output logic       expired,
  output logic       done
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RUN     = 2'd1,
    PAUSE   = 2'd2,
    EXPIRED = 2'd3
  } state_t;

  localparam logic [4:0] HOUR_MAX_C = 5'(HOUR_MAX);
  localparam logic [5:0] SIXTY_M1   = 6'd59;

  state_t     state_q, state_d;
  logic [4:0] hour_q, hour_d;
  logic [5:0] min_q, min_d;
  logic [5:0] sec_q, sec_d;
  logic       running_q, running_d;
  logic       expired_q, expired_d;
  logic       done_q, done_d;

  logic       count_zero;
  logic       dec_to_zero;
  logic       can_start;

  assign count_zero  = (hour_q == 5'd0) && (min_q == 6'd0) && (sec_q == 6'd0);
  // The only way a decrement lands on 00:00:00 is from 00:00:01.
  assign dec_to_zero = (hour_q == 5'd0) && (min_q == 6'd0) && (sec_q == 6'd1);
  assign can_start   = ((state_q == IDLE) || (state_q == PAUSE)) && !count_zero;

  always_comb begin
    state_d = state_q;
    hour_d  = hour_q;
    min_d   = min_q;
    sec_d   = sec_q;
    done_d  = 1'b0;

    if (ld) begin
      hour_d  = (hour_in > HOUR_MAX_C) ? HOUR_MAX_C : hour_in;
      min_d   = (min_in > SIXTY_M1) ? SIXTY_M1 : min_in;
      sec_d   = (sec_in > SIXTY_M1) ? SIXTY_M1 : sec_in;
      state_d = IDLE;
    end else if (stop) begin
      if (state_q == RUN) begin
        state_d = PAUSE;
      end
    end else if (start && can_start) begin
      state_d = RUN;
    end else if (tick && (state_q == RUN)) begin
      if (sec_q != 6'd0) begin
        sec_d = sec_q - 6'd1;
      end else begin
        sec_d = SIXTY_M1;
        if (min_q != 6'd0) begin
          min_d = min_q - 6'd1;
        end else begin
          min_d  = SIXTY_M1;
          hour_d = hour_q - 5'd1;
        end
      end
      if (dec_to_zero) begin
        state_d = EXPIRED;
        done_d  = 1'b1;
      end
    end

    running_d = (state_d == RUN);
    expired_d = (state_d == EXPIRED);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      hour_q    <= 5'd0;
      min_q     <= 6'd0;
      sec_q     <= 6'd0;
      running_q <= 1'b0;
      expired_q <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      hour_q    <= hour_d;
      min_q     <= min_d;
      sec_q     <= sec_d;
      running_q <= running_d;
      expired_q <= expired_d;
      done_q    <= done_d;
    end
  end

  assign hour_out = hour_q;
  assign min_out  = min_q;
  assign sec_out  = sec_q;
  assign running  = running_q;
  assign expired  = expired_q;
  assign done     = done_q;

endmodule

// File: doc/countdown_timer.md
Name: countdown_timer

Overview:
- Hours/minutes/seconds down-counter; the counting-down counterpart to the up-counting time-of-day watch in the same clock subsystem.
- Loads a duration, counts down one second per `tick` enable, and signals expiry with a one-cycle `done` pulse.
- Sits beside the watch and shares its 1 Hz carry/enable source and its hh:mm:ss bus widths.
- Run/pause/expire control is a 4-state FSM.

Parameters:
- HOUR_MAX, 23, largest loadable hour value; hour field width stays 5 bits.

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- rst  input  1  asynchronous reset, active-low.
- ld  input  1  synchronous load of hour_in/min_in/sec_in.
- hour_in  input  5  load value, hours.
- min_in  input  6  load value, minutes.
- sec_in  input  6  load value, seconds.
- tick  input  1  one-cycle 1 Hz count enable (same source as the watch seconds carry-in).
- start  input  1  begin or resume counting.
- stop  input  1  pause counting.
- hour_out  output  5  current remaining hours.
- min_out  output  6  current remaining minutes.
- sec_out  output  6  current remaining seconds.
- running  output  1  high while in state RUN.
- expired  output  1  high while in state EXPIRED.
- done  output  1  one-cycle pulse on reaching 00:00:00 from RUN.

Behaviour:
- Reset (rst=0, asynchronous):
  - hour_out/min_out/sec_out = 0.
  - state = IDLE.
  - running = expired = done = 0.
- All outputs are registered.
- FSM states: IDLE, RUN, PAUSE, EXPIRED.
- Priority each edge: ld > stop > start > tick.
- Load (ld=1, any state):
  - Captures the inputs and forces the state to IDLE.
  - Clamps out-of-range values: sec_in>59 loads 59; min_in>59 loads 59; hour_in>HOUR_MAX loads HOUR_MAX.
  - tick is ignored that cycle.
- start in IDLE or PAUSE:
  - Count nonzero: next state RUN.
  - Count 00:00:00: stays in the current state; done is not pulsed.
- start in RUN or EXPIRED: ignored.
- stop in RUN: next state PAUSE; a tick in the same cycle is discarded (no decrement).
- stop in other states: ignored.
- start and stop in the same cycle: stop wins (RUN goes to PAUSE; IDLE and PAUSE are unchanged).
- Decrement:
  - Occurs only when state=RUN, tick=1, ld=0 and stop=0.
  - Updates on the same edge, so there is 1-cycle latency from tick to the new count.
  - sec>0: sec-1.
  - sec=0: sec=59 and borrow into minutes. min>0: min-1; min=0: min=59 and borrow into hours (hour-1).
  - Hours never wrap: the all-zero count leaves RUN, so no decrement from 00:00:00 is possible.
- Expiry:
  - A decrement that produces 00:00:00 also moves the state to EXPIRED on that edge.
  - done is high for exactly the one cycle following that edge, then low.
  - expired stays high until ld or reset.
- tick in IDLE, PAUSE or EXPIRED: ignored; the count holds.
- start arriving in the same cycle as tick (IDLE/PAUSE): only the transition happens; the first decrement is on the next tick.
- Reset mid-run: count and FSM clear immediately; any pending done is suppressed.
- running = (state==RUN); expired = (state==EXPIRED).

Test Plan:
- Reset then ld 00:01:05, start, 6 ticks -> 00:01:04 after the first tick; 00:00:59 after the 6th tick (minute borrow); running=1.
- ld 01:00:00, start, 1 tick -> 00:59:59 (double borrow); done=0.
- ld 00:00:02, start, 2 ticks -> 00:00:00; state EXPIRED; done high for exactly 1 cycle; expired stays 1; later ticks and start have no effect.
- RUN at 00:00:10, assert stop and tick together -> count stays 00:00:10, state PAUSE; start then tick -> 00:00:09.
- ld hour_in=31, min_in=63, sec_in=60 -> loads 23:59:59; ld 00:00:00 then start -> stays IDLE, done never asserts.
- Mid-count (00:00:01, RUN), pull rst low asynchronously between edges -> outputs go to 0 immediately; no done pulse after release.
